// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter for fetch and data requesters
module mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_DATA_BURST = 4,
    parameter int TIMEOUT        = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_gnt,
    output logic                    if_valid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    output logic                    if_err,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    output logic                    d_gnt,
    output logic                    d_valid,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_err,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic                    mem_ready,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);
    localparam int BE_W = DATA_WIDTH / 8;
    localparam int CW   = $clog2(TIMEOUT) + 1;
    localparam int BW   = $clog2(MAX_DATA_BURST + 1);

    typedef enum logic [1:0] {S_IDLE, S_IF_BUSY, S_D_BUSY} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         tmo_q, tmo_d;
    logic [BW-1:0]         burst_q, burst_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]       mem_be_q, mem_be_d;
    logic                  if_valid_q, if_valid_d, if_err_q, if_err_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic                  d_valid_q, d_valid_d, d_err_q, d_err_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  pick_d, pick_if, d_gnt_c, if_gnt_c;

    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        burst_d     = burst_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_valid_d  = 1'b0;
        if_err_d    = 1'b0;
        if_rdata_d  = '0;
        d_valid_d   = 1'b0;
        d_err_d     = 1'b0;
        d_rdata_d   = '0;
        pick_d      = 1'b0;
        pick_if     = 1'b0;
        d_gnt_c     = 1'b0;
        if_gnt_c    = 1'b0;
        case (state_q)
            S_IDLE: begin
                tmo_d   = '0;
                pick_d  = d_req && !(if_req && burst_q == BW'(MAX_DATA_BURST));
                pick_if = if_req && !pick_d;
                // A port whose response is on the bus this cycle is not granted again.
                d_gnt_c  = pick_d && !d_valid_q && rst;
                if_gnt_c = pick_if && !if_valid_q && rst;
                if (d_gnt_c) begin
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_be_d    = d_be;
                    state_d     = S_D_BUSY;
                    if (!if_req)
                        burst_d = '0;
                    else if (burst_q != BW'(MAX_DATA_BURST))
                        burst_d = burst_q + BW'(1);
                end else if (if_gnt_c) begin
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = '1;
                    state_d     = S_IF_BUSY;
                    burst_d     = '0;
                end
            end
            S_IF_BUSY, S_D_BUSY: begin
                if (mem_ready) begin
                    state_d = S_IDLE;
                    if (state_q == S_IF_BUSY) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end else begin
                        d_valid_d = 1'b1;
                        d_rdata_d = mem_we_q ? '0 : mem_rdata;
                    end
                end else if (tmo_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    if (state_q == S_IF_BUSY) begin
                        if_valid_d = 1'b1;
                        if_err_d   = 1'b1;
                    end else begin
                        d_valid_d = 1'b1;
                        d_err_d   = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            tmo_q       <= '0;
            burst_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_valid_q  <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_valid_q   <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            burst_q     <= burst_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_valid_q  <= if_valid_d;
            if_err_q    <= if_err_d;
            if_rdata_q  <= if_rdata_d;
            d_valid_q   <= d_valid_d;
            d_err_q     <= d_err_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_gnt    = if_gnt_c;
    assign d_gnt     = d_gnt_c;
    assign if_valid  = if_valid_q;
    assign if_err    = if_err_q;
    assign if_rdata  = if_rdata_q;
    assign d_valid   = d_valid_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = (state_q != S_IDLE);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed checks of mem_arbiter arbitration, timeout and reset
module tb_mem_arbiter;
    logic        clk, rst;
    logic        if_req, if_gnt, if_valid, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_valid, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be, mem_be;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;
    int n;
    logic seen;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; if_req = 1'b1; if_addr = 32'h0; d_req = 1'b1; d_we = 1'b0;
        d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
        #12;
        chk("reset_outputs", 32'({if_gnt, d_gnt, mem_req, if_valid, d_valid, mem_we}), 32'h0);
        chk("reset_addr", mem_addr, 32'h0);
        if_req = 1'b0; d_req = 1'b0;
        step();
        rst = 1'b1;
        step();

        // single fetch
        if_req = 1'b1; if_addr = 32'h0000_0010; #1;
        chk("fetch_gnt", 32'({if_gnt, d_gnt, mem_req}), 32'b100);
        step();
        if_req = 1'b0; if_addr = 32'h0; mem_ready = 1'b1; mem_rdata = 32'h0050_0093; #1;
        chk("fetch_busy", 32'({mem_req, mem_we, if_valid}), 32'b100);
        chk("fetch_addr", mem_addr, 32'h0000_0010);
        step();
        mem_ready = 1'b0; #1;
        chk("fetch_valid", 32'({if_valid, if_err, mem_req}), 32'b100);
        chk("fetch_rdata", if_rdata, 32'h0050_0093);
        step();
        chk("fetch_valid_pulse", 32'(if_valid), 32'h0);

        // simultaneous requests, memory always ready
        if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        mem_ready = 1'b1; mem_rdata = 32'h11; #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("burst_dgnt%0d", k), 32'({d_gnt, if_gnt}), 32'b10);
            step();
            chk($sformatf("burst_busy%0d", k), 32'({mem_req, mem_addr == 32'h200}), 32'b11);
            step();
            chk($sformatf("burst_dvalid%0d", k), 32'({d_valid, d_rdata == 32'h11}), 32'b11);
            if (k < 3) begin
                chk($sformatf("burst_hold%0d", k), 32'({d_gnt, if_gnt}), 32'b00);
                step();
            end else begin
                chk("burst_forced_fetch", 32'({d_gnt, if_gnt}), 32'b01);
            end
        end
        step();
        chk("burst_fetch_busy", 32'({mem_req, mem_we, mem_addr == 32'h40}), 32'b101);
        step();
        chk("burst_fetch_valid", 32'({if_valid, if_err}), 32'b10);
        chk("burst_cleared_dgnt", 32'({d_gnt, if_gnt}), 32'b10);
        step();
        if_req = 1'b0; d_req = 1'b0;
        step();
        mem_ready = 1'b0;
        chk("burst_last_dvalid", 32'(d_valid), 32'h1);
        step();

        // store with 3-cycle memory latency
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'hF; #1;
        chk("store_gnt", 32'(d_gnt), 32'h1);
        step();
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
        mem_rdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            mem_ready = (i == 2); #1;
            chk($sformatf("store_ctl%0d", i), 32'({mem_req, mem_we, mem_be}), 32'b11_1111);
            chk($sformatf("store_addr%0d", i), mem_addr, 32'h100);
            chk($sformatf("store_wdata%0d", i), mem_wdata, 32'hDEAD_BEEF);
            step();
        end
        mem_ready = 1'b0;
        chk("store_valid", 32'({d_valid, d_err, mem_req}), 32'b100);
        chk("store_rdata", d_rdata, 32'h0);
        step();

        // timeout on a load
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; mem_rdata = 32'hFFFF_FFFF; #1;
        chk("tmo_gnt", 32'(d_gnt), 32'h1);
        step();
        d_req = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && mem_req; i++) begin
            n++;
            step();
        end
        chk("tmo_req_cycles", 32'(n), 32'd16);
        chk("tmo_valid_err", 32'({d_valid, d_err, mem_req}), 32'b110);
        chk("tmo_rdata", d_rdata, 32'h0);
        if_req = 1'b1; if_addr = 32'h20; #1;
        chk("tmo_next_fetch_gnt", 32'(if_gnt), 32'h1);
        step();
        if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hAA;
        step();
        mem_ready = 1'b0;
        chk("tmo_next_fetch_valid", 32'({if_valid, if_err}), 32'b10);
        chk("tmo_next_fetch_rdata", if_rdata, 32'hAA);
        step();

        // asynchronous reset during D_BUSY
        d_req = 1'b1; d_addr = 32'h400; #1;
        chk("rst_gnt", 32'(d_gnt), 32'h1);
        step();
        d_req = 1'b0; #1;
        chk("rst_busy", 32'(mem_req), 32'h1);
        #2;
        rst = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h55; #1;
        chk("rst_async_outputs", 32'({mem_req, d_valid, d_gnt, if_valid, mem_we}), 32'h0);
        chk("rst_async_addr", mem_addr, 32'h0);
        step();
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            seen = seen | d_valid | mem_req;
        end
        chk("rst_no_response", 32'(seen), 32'h0);
        mem_ready = 1'b0;
        step();

        // mem_ready on the last allowed BUSY cycle
        d_req = 1'b1; d_addr = 32'h500; #1;
        chk("edge_gnt", 32'(d_gnt), 32'h1);
        step();
        d_req = 1'b0;
        repeat (15) step();
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D; #1;
        chk("edge_busy16", 32'(mem_req), 32'h1);
        step();
        mem_ready = 1'b0;
        chk("edge_valid", 32'({d_valid, d_err}), 32'b10);
        chk("edge_rdata", d_rdata, 32'hCAFE_F00D);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences a single-port unified memory shared by two requesters: the instruction-fetch path (PC/InstrMem side) and the data load/store path (DataPath side).
- Arbitrates between them with data priority and an anti-starvation rule, and drives the memory handshake.
- Enforces a response timeout and returns registered responses to each requester.
- Sits between the core and the memory; the core stalls fetch or execute until the matching valid pulse arrives.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data bus width.
- MAX_DATA_BURST, 4, number of consecutive data grants allowed while fetch waits before fetch is forced.
- TIMEOUT, 16, maximum BUSY cycles without mem_ready before the transaction aborts.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request, level.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_valid  out  1  fetch response pulse.
- if_rdata  out  DATA_WIDTH  fetched instruction.
- if_err  out  1  fetch aborted by timeout; qualified by if_valid.
- d_req  in  1  data request, level.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data.
- d_be  in  DATA_WIDTH/8  byte enables.
- d_gnt  out  1  data request accepted this cycle.
- d_valid  out  1  data response pulse (load data or store ack).
- d_rdata  out  DATA_WIDTH  load data; 0 for stores.
- d_err  out  1  data access aborted by timeout; qualified by d_valid.
- mem_req  out  1  memory access active.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_be  out  DATA_WIDTH/8  memory byte enables.
- mem_ready  in  1  memory completes the access this cycle.
- mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ready.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE.
  - All outputs are 0; timeout and burst counters are 0.
  - Any in-flight transaction is dropped with no response.
  - mem_req drops immediately.
- States: IDLE, IF_BUSY, D_BUSY.
- IDLE arbitration (combinational):
  - Only d_req: grant data.
  - Only if_req: grant fetch.
  - Both: grant data unless burst_cnt == MAX_DATA_BURST, in which case grant fetch.
  - Neither: stay in IDLE.
- Grant:
  - The gnt output pulses high for exactly 1 cycle in IDLE.
  - The accepted request fields (addr/we/wdata/be) are latched into the memory-side registers.
  - Next state is IF_BUSY or D_BUSY. The requester may change or drop its inputs after gnt.
- BUSY:
  - mem_req=1 with the latched fields, held stable until completion or abort.
  - mem_we=0 in IF_BUSY.
  - No grants are issued in BUSY; requests stay pending.
- Completion:
  - mem_ready=1 in BUSY → next cycle the matching valid=1 for 1 cycle.
  - rdata is registered from mem_rdata (d_rdata=0 for stores); err=0.
  - State returns to IDLE; IDLE may grant in the same cycle valid is high.
  - Minimum latency gnt→valid is 2 cycles.
- Timeout:
  - Counter clears on entering BUSY and increments each BUSY cycle with mem_ready=0.
  - When it reaches TIMEOUT-1 with mem_ready still 0, the access aborts: mem_req drops the next cycle.
  - The matching valid=1 and err=1 pulse next cycle; rdata=0; state → IDLE.
  - mem_ready on the abort cycle itself counts as completion (ready wins).
- Burst counter:
  - Increments on a data grant while if_req=1, saturating at MAX_DATA_BURST.
  - Clears on any fetch grant, or on a data grant while if_req=0.
- mem_ready outside BUSY is ignored. Valid and gnt are never both high on the same port in the same cycle.

Test Plan:
- Single fetch: if_req=1, addr=0x0000_0010, mem_ready on first BUSY cycle, mem_rdata=0x0050_0093 → if_gnt at cycle 0, mem_req at cycle 1, if_valid at cycle 2 with if_rdata=0x0050_0093, if_err=0.
- Simultaneous requests: if_req=d_req=1 from cycle 0, memory always ready → d_gnt first; back-to-back data grants; after 4 data grants fetch is granted; burst counter is 0 afterwards.
- Store: d_we=1, addr=0x100, wdata=0xDEAD_BEEF, be=0xF, memory ready after 3 cycles → mem_we/addr/wdata stable for all 3 BUSY cycles; d_valid with d_rdata=0.
- Timeout: load with mem_ready held 0 → mem_req high for exactly 16 cycles, then d_valid=1, d_err=1, d_rdata=0; next fetch request is granted normally.
- Reset mid-operation: assert rst=0 during D_BUSY → mem_req and all outputs are 0 asynchronously; after release, no d_valid appears and state is IDLE.
- Ready on timeout boundary: mem_ready=1 exactly at the 16th BUSY cycle → normal completion with err=0 and correct rdata.
